bcd_datetime_editor: RTL and testbench
======================================

Name: bcd_datetime_editor

Overview:
- Front-panel editor between the BCD timekeeper and the 8-digit display driver.
- In display mode it mirrors the live date/time onto the outputs and the digit bus.
- In edit mode it freezes a working copy that the user changes field by field with buttons. The upstream timekeeper loads the *_bcd_out values when edit mode ends.

Parameters:
- YEAR_MIN, 16'h2000, lowest editable year (BCD).
- YEAR_MAX, 16'h2099, highest editable year (BCD).
- ACTIVE_STATE, 4'h0, gobal_state value in which the block accepts buttons.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-high reset (name kept from codebase).
- year_bcd_in  in  16  live year, 4 BCD digits.
- month_bcd_in, day_bcd_in, hour_bcd_in, minute_bcd_in, second_bcd_in  in  8 each  live values, 2 BCD digits each.
- up_btn, down_btn, left_btn, right_btn, enter_btn, return_btn  in  4 each  button event code: 0 none, 1 short press, 2 long press, others ignored. Each code is a single-cycle event.
- gobal_state  in  4  global mode.
- year_bcd_out  out  16  edited or mirrored year.
- month/day/hour/minute/second_bcd_out  out  8 each  edited or mirrored values.
- led0..led7  out  4 each  digit codes; led7 is leftmost; 4'hF means blank.
- blink  out  8  per-digit blink mask; bit i applies to led i.
- dot  out  8  per-digit decimal point.
- is_blink  out  1  high while in EDIT.

Behaviour:
- Registered outputs: all *_bcd_out, state, cursor, is_blink.
  - Reset values: *_bcd_out = 0, state DISPLAY, cursor HOUR, is_blink 0.
- DISPLAY state:
  - Each cycle, *_bcd_out <= *_bcd_in (1-cycle latency).
  - All buttons are ignored except enter_btn == 2.
- Entering EDIT: with gobal_state == ACTIVE_STATE and enter_btn == 2, capture *_bcd_in into *_bcd_out, set cursor to HOUR, go to EDIT, set is_blink = 1.
- EDIT state:
  - *_bcd_out hold the working copy; nothing ticks.
  - Exactly one action per cycle, priority return > enter > up > down > left > right.
- Actions in EDIT:
  - return_btn != 0, or gobal_state != ACTIVE_STATE: abort. Load *_bcd_in into *_bcd_out and go to DISPLAY.
  - enter_btn == 1: commit. Go to DISPLAY; *_bcd_out keep the edited values for the first DISPLAY cycle, then resume mirroring.
  - enter_btn == 2: ignored.
  - up_btn / down_btn != 0: step the selected field by +1 / -1 with wrap.
  - right_btn / left_btn != 0: cursor +1 / -1, wrapping 5<->0.
- Cursor order: HOUR(0), MINUTE(1), SECOND(2), YEAR(3), MONTH(4), DAY(5).
- Upstream contract: the timekeeper loads *_bcd_out in the first cycle where is_blink has fallen from 1 to 0. An abort delivers the live values, so the load is harmless.
- Field ranges (valid BCD maintained at all times; both directions wrap):
  - hour 00-23; minute and second 00-59; month 01-12.
  - year YEAR_MIN..YEAR_MAX.
  - day 01..dim(year, month); February has 29 days when the year is divisible by 4.
  - After any year or month step, day is clamped to the new dim.
- Display mapping (combinational from state, cursor and *_bcd_out):
  - Time page, used in DISPLAY and for cursor 0-2:
    - led7, led6 = F; led5..4 = hour; led3..2 = minute; led1..0 = second.
    - dot = 8'b0001_0100.
  - Date page, used for cursor 3-5:
    - led7..4 = year; led3..2 = month; led1..0 = day.
    - dot = 8'b0001_0100.
  - blink is 0 in DISPLAY. In EDIT it marks the selected field's digits:
    - hour 8'h30, minute 8'h0C, second 8'h03.
    - year 8'hF0, month 8'h0C, day 8'h03.
- Reset mid-edit returns to DISPLAY; the working copy is discarded.

Decomposition:
- Shared package holds:
  - state enum (DISPLAY, EDIT).
  - cursor enum (field codes 0-5).
  - button codes BTN_NONE = 0, BTN_SHORT = 1, BTN_LONG = 2.
  - LED_BLANK = 4'hF.
  - blink mask constants.
- One sub-module, bcd_field_step:
  - Inputs: 2-digit BCD value, min, max, direction.
  - Output: wrapped next value.
  - Instantiated for hour, minute, second, month and day; year uses a 4-digit variant or a parameterized width.

Test Plan:
- Reset, inputs 2024-03-15 10:30:00, release reset, wait 2 cycles -> outputs mirror the inputs; led5..0 = 1,0,3,0,0,0; blink 0; is_blink 0.
- enter_btn = 2 for 1 cycle -> is_blink 1; blink 8'h30; up_btn = 1 -> hour_bcd_out 11; other outputs unchanged.
- In EDIT: right_btn = 1 then up_btn = 1 -> minute 31, blink 8'h0C. Change second_bcd_in to 05 -> second_bcd_out stays 00.
- enter_btn = 1 -> is_blink 0; first cycle outputs 11:31:00; next cycle outputs equal the inputs again.
- Edit with year 2023, cursor MONTH at 01, day set to 31, up on MONTH -> month 02, day clamped to 28. With year 2024 -> day 29.
- Wrap checks: hour 23 +1 -> 00; minute 00 -1 -> 59; left from HOUR -> cursor DAY, date page shown, blink 8'h03. return_btn = 1 -> outputs revert to the inputs.

Source files
------------

// File: rtl/bcd_datetime_editor_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bcd_datetime_editor_pkg
// Purpose : Shared types, button codes, display constants and calendar
//           helpers for the BCD date/time front-panel editor.
// Revision: 1.0  initial release
// ============================================================================
package bcd_datetime_editor_pkg;

    typedef enum logic [0:0] {
        ST_DISPLAY = 1'b0,
        ST_EDIT    = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        CUR_HOUR   = 3'd0,
        CUR_MINUTE = 3'd1,
        CUR_SECOND = 3'd2,
        CUR_YEAR   = 3'd3,
        CUR_MONTH  = 3'd4,
        CUR_DAY    = 3'd5
    } cursor_t;

    localparam logic [3:0] BTN_NONE  = 4'd0;
    localparam logic [3:0] BTN_SHORT = 4'd1;
    localparam logic [3:0] BTN_LONG  = 4'd2;

    localparam logic [3:0] LED_BLANK = 4'hF;

    localparam logic [7:0] BLINK_HOUR   = 8'h30;
    localparam logic [7:0] BLINK_MINUTE = 8'h0C;
    localparam logic [7:0] BLINK_SECOND = 8'h03;
    localparam logic [7:0] BLINK_YEAR   = 8'hF0;
    localparam logic [7:0] BLINK_MONTH  = 8'h0C;
    localparam logic [7:0] BLINK_DAY    = 8'h03;

    localparam logic [7:0] DOT_PAGE     = 8'b0001_0100;

    // Only codes 1 and 2 are real events; anything else is noise.
    function automatic logic btn_pressed(input logic [3:0] code);
        return (code == BTN_SHORT) || (code == BTN_LONG);
    endfunction

    // Leap when the two low year digits form a multiple of 4; since 100 is a
    // multiple of 4 the century digits never matter. (10*t + o) mod 4 equals
    // (2*t + o) mod 4.
    function automatic logic is_leap(input logic [7:0] yy);
        logic [4:0] v;
        v = {yy[7:4], 1'b0} + {1'b0, yy[3:0]};
        return (v[1:0] == 2'b00);
    endfunction

    // Days in month as 2-digit BCD.
    function automatic logic [7:0] days_in_month(input logic [7:0] yy,
                                                 input logic [7:0] mm);
        logic [7:0] d;
        case (mm)
            8'h02:                      d = is_leap(yy) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: d = 8'h30;
            default:                    d = 8'h31;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_datetime_editor_field_step.sv
`default_nettype none
// ============================================================================
// Module  : bcd_field_step
// Purpose : One BCD increment/decrement of an N-digit field, wrapping
//           between min_val and max_val in both directions.
// Revision: 1.0  initial release
// ============================================================================
module bcd_field_step #(
    parameter int DIGITS = 2
) (
    input  logic [4*DIGITS-1:0] value,
    input  logic [4*DIGITS-1:0] min_val,
    input  logic [4*DIGITS-1:0] max_val,
    input  logic                up,
    output logic [4*DIGITS-1:0] next_val
);

    logic [4*DIGITS-1:0] w_inc;
    logic [4*DIGITS-1:0] w_dec;

    // Digit-serial BCD +1 and -1 with ripple carry/borrow.
    always_comb begin
        logic carry;
        logic borrow;
        w_inc  = value;
        w_dec  = value;
        carry  = 1'b1;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (value[4*i +: 4] >= 4'd9) begin
                    w_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_inc[4*i +: 4] = value[4*i +: 4] + 4'd1;
                    carry           = 1'b0;
                end
            end
            if (borrow) begin
                if (value[4*i +: 4] == 4'd0) begin
                    w_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_dec[4*i +: 4] = value[4*i +: 4] - 4'd1;
                    borrow          = 1'b0;
                end
            end
        end
    end

    // Valid BCD orders like unsigned binary, so plain compares pick the wrap.
    always_comb begin
        if (up) begin
            next_val = (value >= max_val) ? min_val : w_inc;
        end else begin
            next_val = (value <= min_val) ? max_val : w_dec;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_datetime_editor.sv
`default_nettype none
// ============================================================================
// Module  : bcd_datetime_editor
// Purpose : Front-panel date/time editor. Mirrors the live BCD date/time in
//           display mode; in edit mode holds a working copy changed field by
//           field through button events, and drives the 8-digit display.
// Revision: 1.0  initial release
// ============================================================================
module bcd_datetime_editor
    import bcd_datetime_editor_pkg::*;
#(
    parameter logic [15:0] YEAR_MIN     = 16'h2000,
    parameter logic [15:0] YEAR_MAX     = 16'h2099,
    parameter logic [3:0]  ACTIVE_STATE = 4'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] year_bcd_in,
    input  logic [7:0]  month_bcd_in,
    input  logic [7:0]  day_bcd_in,
    input  logic [7:0]  hour_bcd_in,
    input  logic [7:0]  minute_bcd_in,
    input  logic [7:0]  second_bcd_in,
    input  logic [3:0]  up_btn,
    input  logic [3:0]  down_btn,
    input  logic [3:0]  left_btn,
    input  logic [3:0]  right_btn,
    input  logic [3:0]  enter_btn,
    input  logic [3:0]  return_btn,
    input  logic [3:0]  gobal_state,
    output logic [15:0] year_bcd_out,
    output logic [7:0]  month_bcd_out,
    output logic [7:0]  day_bcd_out,
    output logic [7:0]  hour_bcd_out,
    output logic [7:0]  minute_bcd_out,
    output logic [7:0]  second_bcd_out,
    output logic [3:0]  led0,
    output logic [3:0]  led1,
    output logic [3:0]  led2,
    output logic [3:0]  led3,
    output logic [3:0]  led4,
    output logic [3:0]  led5,
    output logic [3:0]  led6,
    output logic [3:0]  led7,
    output logic [7:0]  blink,
    output logic [7:0]  dot,
    output logic        is_blink
);

    state_t      r_state;
    cursor_t     r_cursor;

    state_t      w_state_next;
    cursor_t     w_cursor_next;
    logic        w_is_blink_next;
    logic [15:0] w_year_next;
    logic [7:0]  w_month_next;
    logic [7:0]  w_day_next;
    logic [7:0]  w_hour_next;
    logic [7:0]  w_minute_next;
    logic [7:0]  w_second_next;

    logic        w_up;
    logic [15:0] w_year_step;
    logic [7:0]  w_month_step;
    logic [7:0]  w_day_step;
    logic [7:0]  w_hour_step;
    logic [7:0]  w_minute_step;
    logic [7:0]  w_second_step;
    logic [7:0]  w_dim_cur;
    logic [7:0]  w_dim_year;
    logic [7:0]  w_dim_month;

    // Up wins over down when both arrive together.
    assign w_up        = btn_pressed(up_btn);
    assign w_dim_cur   = days_in_month(year_bcd_out[7:0], month_bcd_out);
    assign w_dim_year  = days_in_month(w_year_step[7:0], month_bcd_out);
    assign w_dim_month = days_in_month(year_bcd_out[7:0], w_month_step);

    bcd_field_step #(.DIGITS(2)) u_step_hour (
        .value(hour_bcd_out), .min_val(8'h00), .max_val(8'h23),
        .up(w_up), .next_val(w_hour_step));
    bcd_field_step #(.DIGITS(2)) u_step_minute (
        .value(minute_bcd_out), .min_val(8'h00), .max_val(8'h59),
        .up(w_up), .next_val(w_minute_step));
    bcd_field_step #(.DIGITS(2)) u_step_second (
        .value(second_bcd_out), .min_val(8'h00), .max_val(8'h59),
        .up(w_up), .next_val(w_second_step));
    bcd_field_step #(.DIGITS(2)) u_step_month (
        .value(month_bcd_out), .min_val(8'h01), .max_val(8'h12),
        .up(w_up), .next_val(w_month_step));
    bcd_field_step #(.DIGITS(2)) u_step_day (
        .value(day_bcd_out), .min_val(8'h01), .max_val(w_dim_cur),
        .up(w_up), .next_val(w_day_step));
    bcd_field_step #(.DIGITS(4)) u_step_year (
        .value(year_bcd_out), .min_val(YEAR_MIN), .max_val(YEAR_MAX),
        .up(w_up), .next_val(w_year_step));

    // Next-state and next working-copy decode; one action per cycle in EDIT.
    always_comb begin
        w_state_next    = r_state;
        w_cursor_next   = r_cursor;
        w_is_blink_next = is_blink;
        w_year_next     = year_bcd_out;
        w_month_next    = month_bcd_out;
        w_day_next      = day_bcd_out;
        w_hour_next     = hour_bcd_out;
        w_minute_next   = minute_bcd_out;
        w_second_next   = second_bcd_out;

        case (r_state)
            ST_DISPLAY: begin
                w_year_next   = year_bcd_in;
                w_month_next  = month_bcd_in;
                w_day_next    = day_bcd_in;
                w_hour_next   = hour_bcd_in;
                w_minute_next = minute_bcd_in;
                w_second_next = second_bcd_in;
                if ((gobal_state == ACTIVE_STATE) && (enter_btn == BTN_LONG)) begin
                    w_state_next    = ST_EDIT;
                    w_cursor_next   = CUR_HOUR;
                    w_is_blink_next = 1'b1;
                end
            end

            ST_EDIT: begin
                if (btn_pressed(return_btn) || (gobal_state != ACTIVE_STATE)) begin
                    // Abort hands the live values upstream so its load is a no-op.
                    w_year_next     = year_bcd_in;
                    w_month_next    = month_bcd_in;
                    w_day_next      = day_bcd_in;
                    w_hour_next     = hour_bcd_in;
                    w_minute_next   = minute_bcd_in;
                    w_second_next   = second_bcd_in;
                    w_state_next    = ST_DISPLAY;
                    w_is_blink_next = 1'b0;
                end else if (enter_btn == BTN_SHORT) begin
                    // Commit: edited values stay visible for one DISPLAY cycle.
                    w_state_next    = ST_DISPLAY;
                    w_is_blink_next = 1'b0;
                end else if (enter_btn == BTN_LONG) begin
                    // Long enter is swallowed: it takes the cycle's action slot.
                    w_state_next = ST_EDIT;
                end else if (w_up || btn_pressed(down_btn)) begin
                    case (r_cursor)
                        CUR_HOUR:   w_hour_next   = w_hour_step;
                        CUR_MINUTE: w_minute_next = w_minute_step;
                        CUR_SECOND: w_second_next = w_second_step;
                        CUR_YEAR: begin
                            w_year_next = w_year_step;
                            w_day_next  = (day_bcd_out > w_dim_year) ? w_dim_year : day_bcd_out;
                        end
                        CUR_MONTH: begin
                            w_month_next = w_month_step;
                            w_day_next   = (day_bcd_out > w_dim_month) ? w_dim_month : day_bcd_out;
                        end
                        default:    w_day_next    = w_day_step;
                    endcase
                end else if (btn_pressed(left_btn)) begin
                    w_cursor_next = (r_cursor == CUR_HOUR) ? CUR_DAY
                                                           : cursor_t'(r_cursor - 3'd1);
                end else if (btn_pressed(right_btn)) begin
                    w_cursor_next = (r_cursor == CUR_DAY) ? CUR_HOUR
                                                          : cursor_t'(r_cursor + 3'd1);
                end
            end

            default: begin
                w_state_next    = ST_DISPLAY;
                w_is_blink_next = 1'b0;
            end
        endcase
    end

    // State, cursor and working-copy registers; reset discards any edit.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state        <= ST_DISPLAY;
            r_cursor       <= CUR_HOUR;
            is_blink       <= 1'b0;
            year_bcd_out   <= 16'h0000;
            month_bcd_out  <= 8'h00;
            day_bcd_out    <= 8'h00;
            hour_bcd_out   <= 8'h00;
            minute_bcd_out <= 8'h00;
            second_bcd_out <= 8'h00;
        end else begin
            r_state        <= w_state_next;
            r_cursor       <= w_cursor_next;
            is_blink       <= w_is_blink_next;
            year_bcd_out   <= w_year_next;
            month_bcd_out  <= w_month_next;
            day_bcd_out    <= w_day_next;
            hour_bcd_out   <= w_hour_next;
            minute_bcd_out <= w_minute_next;
            second_bcd_out <= w_second_next;
        end
    end

    // Display page select and blink mask for the selected field.
    always_comb begin
        dot   = DOT_PAGE;
        blink = 8'h00;
        if ((r_state == ST_DISPLAY) || (r_cursor < CUR_YEAR)) begin
            led7 = LED_BLANK;
            led6 = LED_BLANK;
            led5 = hour_bcd_out[7:4];
            led4 = hour_bcd_out[3:0];
            led3 = minute_bcd_out[7:4];
            led2 = minute_bcd_out[3:0];
            led1 = second_bcd_out[7:4];
            led0 = second_bcd_out[3:0];
        end else begin
            led7 = year_bcd_out[15:12];
            led6 = year_bcd_out[11:8];
            led5 = year_bcd_out[7:4];
            led4 = year_bcd_out[3:0];
            led3 = month_bcd_out[7:4];
            led2 = month_bcd_out[3:0];
            led1 = day_bcd_out[7:4];
            led0 = day_bcd_out[3:0];
        end
        if (r_state == ST_EDIT) begin
            case (r_cursor)
                CUR_HOUR:   blink = BLINK_HOUR;
                CUR_MINUTE: blink = BLINK_MINUTE;
                CUR_SECOND: blink = BLINK_SECOND;
                CUR_YEAR:   blink = BLINK_YEAR;
                CUR_MONTH:  blink = BLINK_MONTH;
                default:    blink = BLINK_DAY;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_datetime_editor.sv
`default_nettype none
// ============================================================================
// Module  : tb_bcd_datetime_editor
// Purpose : Directed self-checking bench for bcd_datetime_editor.
// Revision: 1.0  initial release
// ============================================================================
module tb_bcd_datetime_editor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] year_in;
    logic [7:0]  month_in, day_in, hour_in, minute_in, second_in;
    logic [3:0]  up_btn, down_btn, left_btn, right_btn, enter_btn, return_btn;
    logic [3:0]  gobal_state;
    logic [15:0] year_out;
    logic [7:0]  month_out, day_out, hour_out, minute_out, second_out;
    logic [3:0]  led0, led1, led2, led3, led4, led5, led6, led7;
    logic [7:0]  blink, dot;
    logic        is_blink;

    int tests = 0;
    int fails = 0;

    bcd_datetime_editor dut (
        .clk(clk), .rst_n(rst_n),
        .year_bcd_in(year_in), .month_bcd_in(month_in), .day_bcd_in(day_in),
        .hour_bcd_in(hour_in), .minute_bcd_in(minute_in), .second_bcd_in(second_in),
        .up_btn(up_btn), .down_btn(down_btn), .left_btn(left_btn),
        .right_btn(right_btn), .enter_btn(enter_btn), .return_btn(return_btn),
        .gobal_state(gobal_state),
        .year_bcd_out(year_out), .month_bcd_out(month_out), .day_bcd_out(day_out),
        .hour_bcd_out(hour_out), .minute_bcd_out(minute_out), .second_bcd_out(second_out),
        .led0(led0), .led1(led1), .led2(led2), .led3(led3),
        .led4(led4), .led5(led5), .led6(led6), .led7(led7),
        .blink(blink), .dot(dot), .is_blink(is_blink)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle button event: 0 up,1 down,2 left,3 right,4 enter,5 return.
    task automatic press(input int which, input logic [3:0] code);
        case (which)
            0: up_btn     = code;
            1: down_btn   = code;
            2: left_btn   = code;
            3: right_btn  = code;
            4: enter_btn  = code;
            default: return_btn = code;
        endcase
        tick();
        up_btn = 0; down_btn = 0; left_btn = 0; right_btn = 0; enter_btn = 0; return_btn = 0;
    endtask

    task automatic set_inputs(input logic [15:0] y, input logic [7:0] mo, input logic [7:0] d,
                              input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
        year_in = y; month_in = mo; day_in = d; hour_in = h; minute_in = mi; second_in = s;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        set_inputs(16'h2024, 8'h03, 8'h15, 8'h10, 8'h30, 8'h00);
        tick(); tick();
        tests++;
        if ({year_out, month_out, day_out, hour_out, minute_out, second_out, is_blink} !== 57'd0) begin
            fails++; $display("FAIL reset_values got %h want 0",
                {year_out, month_out, day_out, hour_out, minute_out, second_out, is_blink});
        end
        rst_n = 1'b0;
        tick(); tick();
        tests++;
        if ({year_out, month_out, day_out, hour_out, minute_out, second_out} !== 56'h2024_03_15_10_30_00) begin
            fails++; $display("FAIL mirror got %h want 20240315103000",
                {year_out, month_out, day_out, hour_out, minute_out, second_out});
        end
        tests++;
        if ({led7, led6, led5, led4, led3, led2, led1, led0} !== 32'hFF10_3000) begin
            fails++; $display("FAIL time_page_leds got %h want FF103000",
                {led7, led6, led5, led4, led3, led2, led1, led0});
        end
        tests++;
        if ({blink, dot, is_blink} !== {8'h00, 8'h14, 1'b0}) begin
            fails++; $display("FAIL display_blink_dot got %h/%h/%b want 00/14/0", blink, dot, is_blink);
        end
    endtask

    task automatic test_enter_and_step_hour();
        press(4, 4'd2);
        tests++;
        if ({is_blink, blink} !== {1'b1, 8'h30}) begin
            fails++; $display("FAIL enter_edit got %b/%h want 1/30", is_blink, blink);
        end
        press(0, 4'd1);
        tests++;
        if ({year_out, month_out, day_out, hour_out, minute_out, second_out} !== 56'h2024_03_15_11_30_00) begin
            fails++; $display("FAIL hour_up got %h want 20240315113000",
                {year_out, month_out, day_out, hour_out, minute_out, second_out});
        end
    endtask

    task automatic test_cursor_and_freeze();
        press(3, 4'd1);
        press(0, 4'd1);
        tests++;
        if ({minute_out, blink} !== {8'h31, 8'h0C}) begin
            fails++; $display("FAIL minute_up got %h/%h want 31/0C", minute_out, blink);
        end
        second_in = 8'h05;
        tick();
        tests++;
        if (second_out !== 8'h00) begin
            fails++; $display("FAIL frozen_second got %h want 00", second_out);
        end
    endtask

    task automatic test_commit();
        press(4, 4'd1);
        tests++;
        if ({is_blink, hour_out, minute_out, second_out} !== {1'b0, 24'h11_31_00}) begin
            fails++; $display("FAIL commit_hold got %b/%h want 0/113100",
                is_blink, {hour_out, minute_out, second_out});
        end
        tick();
        tests++;
        if ({hour_out, minute_out, second_out, blink} !== {24'h10_30_05, 8'h00}) begin
            fails++; $display("FAIL commit_resume got %h want 10300500",
                {hour_out, minute_out, second_out, blink});
        end
    endtask

    task automatic test_month_clamp();
        set_inputs(16'h2023, 8'h01, 8'h31, 8'h10, 8'h30, 8'h05);
        tick();
        press(4, 4'd2);
        press(2, 4'd1);
        tests++;
        if ({blink, led7, led6, led5, led4, led3, led2, led1, led0} !== {8'h03, 32'h2023_0131}) begin
            fails++; $display("FAIL day_cursor_page got %h want 0320230131",
                {blink, led7, led6, led5, led4, led3, led2, led1, led0});
        end
        press(2, 4'd1);
        press(0, 4'd1);
        tests++;
        if ({blink, month_out, day_out} !== 24'h0C_02_28) begin
            fails++; $display("FAIL clamp_2023 got %h want 0C0228", {blink, month_out, day_out});
        end
        press(5, 4'd1);
        tests++;
        if ({is_blink, month_out, day_out} !== {1'b0, 16'h01_31}) begin
            fails++; $display("FAIL abort_revert got %b/%h want 0/0131", is_blink, {month_out, day_out});
        end
        year_in = 16'h2024;
        tick();
        press(4, 4'd2);
        press(2, 4'd1);
        press(2, 4'd1);
        press(0, 4'd1);
        tests++;
        if ({year_out, month_out, day_out, dot} !== 40'h2024_02_29_14) begin
            fails++; $display("FAIL clamp_2024 got %h want 20240229_14", {year_out, month_out, day_out, dot});
        end
        press(5, 4'd1);
    endtask

    task automatic test_wraps();
        set_inputs(16'h2024, 8'h03, 8'h15, 8'h23, 8'h00, 8'h00);
        tick();
        press(4, 4'd2);
        press(0, 4'd1);
        tests++;
        if (hour_out !== 8'h00) begin
            fails++; $display("FAIL hour_wrap got %h want 00", hour_out);
        end
        press(3, 4'd1);
        press(1, 4'd1);
        tests++;
        if (minute_out !== 8'h59) begin
            fails++; $display("FAIL minute_wrap got %h want 59", minute_out);
        end
        press(2, 4'd1);
        press(2, 4'd1);
        tests++;
        if ({blink, led7, led6, led5, led4} !== 24'h03_2024) begin
            fails++; $display("FAIL cursor_wrap got %h want 032024", {blink, led7, led6, led5, led4});
        end
        press(5, 4'd1);
        tests++;
        if ({is_blink, hour_out, minute_out} !== {1'b0, 16'h23_00}) begin
            fails++; $display("FAIL return_revert got %b/%h want 0/2300", is_blink, {hour_out, minute_out});
        end
    endtask

    task automatic test_global_state();
        gobal_state = 4'h3;
        press(4, 4'd2);
        tests++;
        if (is_blink !== 1'b0) begin
            fails++; $display("FAIL inactive_enter got %b want 0", is_blink);
        end
        gobal_state = 4'h0;
        press(4, 4'd2);
        press(0, 4'd1);
        gobal_state = 4'h3;
        tick();
        tests++;
        if ({is_blink, hour_out} !== {1'b0, 8'h23}) begin
            fails++; $display("FAIL global_abort got %b/%h want 0/23", is_blink, hour_out);
        end
        gobal_state = 4'h0;
    endtask

    task automatic test_reset_mid_edit();
        press(4, 4'd2);
        press(0, 4'd1);
        rst_n = 1'b1;
        tick();
        tests++;
        if ({is_blink, blink, hour_out} !== {1'b0, 8'h00, 8'h00}) begin
            fails++; $display("FAIL reset_mid_edit got %b/%h/%h want 0/00/00", is_blink, blink, hour_out);
        end
        rst_n = 1'b0;
        tick(); tick();
        tests++;
        if ({is_blink, hour_out} !== {1'b0, 8'h23}) begin
            fails++; $display("FAIL after_reset_mirror got %b/%h want 0/23", is_blink, hour_out);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        up_btn = 0; down_btn = 0; left_btn = 0; right_btn = 0; enter_btn = 0; return_btn = 0;
        gobal_state = 4'h0;
        set_inputs(16'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
        test_reset();
        test_enter_and_step_hour();
        test_cursor_and_freeze();
        test_commit();
        test_month_clamp();
        test_wraps();
        test_global_state();
        test_reset_mid_edit();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
